// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared operator encodings, constants and state type for the bext/bdep unit
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS         = 3;
    localparam int unsigned BEXT_BDEP_DEFAULT_BPC = 8;

    typedef enum logic [7:0] {
        ADD,
        SUB,
        ANDL,
        ORL,
        XORL,
        MUL,
        MULH,
        DIV,
        REM,
        BEXT,
        BDEP
    } fu_op;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } bext_bdep_state_t;

endpackage

// File: rtl/bext_bdep_unit_chunk.sv
// rtl/bext_bdep_unit_chunk.sv - combinational single-chunk bit-extract/bit-deposit step
module bext_bdep_chunk
    import ariane_pkg::*;
#(
    parameter int unsigned B = 8
) (
    input  fu_op        op_i,
    input  logic [63:0] a_i,
    input  logic [B-1:0] mask_i,
    input  logic [5:0]  base_i,
    input  logic [6:0]  k_i,
    input  logic [63:0] res_i,
    output logic [63:0] res_o,
    output logic [6:0]  k_o
);

    logic [63:0] res;
    logic [6:0]  k;
    logic [5:0]  p;

    // Walk the chunk's mask bits low to high, moving one data bit per set mask bit.
    always_comb begin
        res = res_i;
        k   = k_i;
        p   = '0;
        for (int j = 0; j < int'(B); j++) begin
            p = base_i + 6'(j);
            if (mask_i[j] && (k < 7'd64)) begin
                if (op_i == BEXT) begin
                    res[k[5:0]] = a_i[p];
                end else begin
                    res[p] = a_i[k[5:0]];
                end
                k = k + 7'd1;
            end
        end
    end

    assign res_o = res;
    assign k_o   = k;

endmodule

// File: rtl/bext_bdep_unit.sv
// rtl/bext_bdep_unit.sv - iterative 64-bit BEXT/BDEP engine; BEXT_BDEP_EARLY_EXIT_EN enables early exit
module bext_bdep_unit
    import ariane_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = ariane_pkg::BEXT_BDEP_DEFAULT_BPC,
    parameter int unsigned TRANS_ID_BITS  = ariane_pkg::TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  fu_op                     operator_i,
    input  logic [63:0]              operand_a_i,
    input  logic [63:0]              operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic [63:0]              result_o,
    output logic                     result_valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam int unsigned N  = 64 / BITS_PER_CYCLE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    bext_bdep_state_t         state_q, state_d;
    fu_op                     op_q;
    logic [63:0]              a_q, mask_q, acc_q, result_q;
    logic [6:0]               k_q;
    logic [CW-1:0]            i_q;
    logic [TRANS_ID_BITS-1:0] id_q;

    logic [5:0]  base;
    logic [63:0] res_step;
    logic [6:0]  k_step;
    logic        chunk_last;
    logic        accept;
    logic        load_result;

    assign base = 6'(32'(i_q) * BITS_PER_CYCLE);

    bext_bdep_chunk #(.B(BITS_PER_CYCLE)) u_chunk (
        .op_i   (op_q),
        .a_i    (a_q),
        .mask_i (mask_q[base +: BITS_PER_CYCLE]),
        .base_i (base),
        .k_i    (k_q),
        .res_i  (acc_q),
        .res_o  (res_step),
        .k_o    (k_step)
    );

`ifdef BEXT_BDEP_EARLY_EXIT_EN
    logic [6:0] next_base;
    assign next_base  = 7'(base) + 7'(BITS_PER_CYCLE);
    // Stop as soon as no set mask bits remain above the chunk just processed.
    assign chunk_last = (i_q == CW'(N - 1)) || ((mask_q >> next_base) == 64'd0);
`else
    assign chunk_last = (i_q == CW'(N - 1));
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and completion outputs; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        ready_o        = (state_q == IDLE) || (state_q == DONE);
        busy_o         = (state_q == BUSY);
        result_valid_o = (state_q == DONE) && !flush_i;
        accept         = valid_i && ready_o && !flush_i &&
                         ((operator_i == BEXT) || (operator_i == BDEP));
        load_result    = (state_q == BUSY) && chunk_last && !flush_i;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (chunk_last) state_d = DONE;
            DONE:    state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Operand capture, per-chunk accumulation and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= ADD;
            a_q      <= '0;
            mask_q   <= '0;
            id_q     <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= operator_i;
            a_q    <= operand_a_i;
            mask_q <= operand_b_i;
            id_q   <= trans_id_i;
            acc_q  <= '0;
            k_q    <= '0;
            i_q    <= '0;
        end else if (state_q == BUSY) begin
            acc_q <= res_step;
            k_q   <= k_step;
            i_q   <= i_q + CW'(1);
            if (load_result) begin
                result_q <= res_step;
            end
        end
    end

    assign result_o   = result_q;
    assign trans_id_o = id_q;

endmodule

// File: doc/bext_bdep_unit.md
Name: bext_bdep_unit

Overview:
- Iterative bit-extract (BEXT) and bit-deposit (BDEP) engine for 64-bit operands.
- Sits directly upstream of the multiplier. Its result_o and busy_o drive the multiplier's multi_cycle_result_i and multi_cycle_i; the multiplier muxes the result onto its writeback port.
- Processes BITS_PER_CYCLE mask bits per cycle. This trades latency for area against a fully combinational 64-bit compress/expand network.

Parameters:
- BITS_PER_CYCLE, default 8: mask bits consumed per cycle. Legal values are 1, 2, 4, 8, 16, 32, 64. N = 64/BITS_PER_CYCLE.
- TRANS_ID_BITS, default ariane_pkg value: transaction ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- flush_i  in  1  kill any in-flight operation
- valid_i  in  1  operation request
- operator_i  in  fu_op  only BEXT and BDEP are acted on
- operand_a_i  in  64  rs1 data
- operand_b_i  in  64  rs2 mask
- trans_id_i  in  TRANS_ID_BITS  transaction ID
- ready_o  out  1  can accept a new operation this cycle
- busy_o  out  1  operation in flight, to multiplier multi_cycle_i
- result_o  out  64  registered result, to multiplier multi_cycle_result_i
- result_valid_o  out  1  one-cycle completion pulse
- trans_id_o  out  TRANS_ID_BITS  ID of the completed operation

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset values: state=IDLE, result_o=0, result_valid_o=0, busy_o=0, trans_id_o=0, ready_o=1. Chunk counter and k are cleared.
- ready_o = (state==IDLE) | (state==DONE).
- Accept: valid_i & ready_o & ~flush_i & operator_i in {BEXT,BDEP}.
  - On accept, latch operator, a, mask and trans_id.
  - Clear the result accumulator, chunk index i, and k (7-bit count of set mask bits consumed).
  - Go to BUSY.
  - Any other operator with valid_i is ignored and the state is unchanged.
- BUSY, chunk i processing. For p = i*B .. i*B+B-1, in ascending order, if mask[p]=1:
  - BEXT: res[k] = a[p]; k = k+1.
  - BDEP: res[p] = a[k]; k = k+1.
  - k never exceeds 64 and an index is only used while k < 64.
- Transitions:
  - i increments each BUSY cycle.
  - After chunk N-1, go to DONE and load result_o from the accumulator.
- busy_o = (state==BUSY).
- DONE:
  - result_valid_o = 1 for exactly one cycle, masked combinationally by flush_i.
  - trans_id_o = latched ID.
  - Next state is IDLE, or BUSY if a new accept occurs in the same cycle (back-to-back).
- Latency: accept at cycle T0, BUSY cycles T1..TN, result_valid_o at T(N+1). For the default, that is 9 cycles.
- Throughput: one operation per N+1 cycles.
- result_o holds its value until the next completion. It does not change during BUSY, so the multiplier's one-cycle-delayed select sees a stable value.
- flush_i:
  - In any state, next state is IDLE and no result_valid_o is produced.
  - result_o keeps its old value.
  - flush_i coincident with valid_i means no accept.
- No backpressure: the consumer must take result_valid_o when it pulses.
- Reset asserted mid-BUSY returns all outputs to their reset values immediately.

Optional Feature:
- Macro: BEXT_BDEP_EARLY_EXIT_EN.
- When defined: after processing chunk i, if mask bits [63:(i+1)*B] are all zero, go directly to DONE. A zero mask gives latency 2 (one BUSY cycle).
- When undefined: always N BUSY cycles; latency is fixed at N+1.
- Results are identical either way; only latency differs.

Decomposition:
- ariane_pkg:
  - Existing fu_op values BEXT and BDEP.
  - New constant BEXT_BDEP_DEFAULT_BPC = 8.
  - State enum typedef bext_bdep_state_t {IDLE, BUSY, DONE}.
- Sub-module bext_bdep_chunk: purely combinational single-chunk step.
  - Inputs: operator, a, mask slice, chunk base index, k_in, res_in.
  - Outputs: res_out, k_out.
  - The top level holds the FSM, counter and registers.

Test Plan:
1. BEXT, a=0xFFFF_0000_1234_5678, mask=0x0000_0000_0000_FF00, trans_id=3 -> result_valid_o at T0+9, result_o=0x56, trans_id_o=3.
2. BDEP, a=0xAB, mask=0xFF00_0000_0000_0000 -> result_o=0xAB00_0000_0000_0000 at T0+9.
3. Masks all-ones and zero:
   - mask=all-ones -> BEXT and BDEP both return a=0x0123_4567_89AB_CDEF.
   - mask=0 -> result 0, latency 9, or 2 with BEXT_BDEP_EARLY_EXIT_EN.
4. flush_i at T0+4 during BUSY -> no result_valid_o; ready_o=1 at T0+5; a following BEXT gives the correct result and result_o keeps its previous value until then.
5. Back-to-back and ignored operators:
   - New BDEP with valid_i in the DONE cycle -> accepted, second result_valid_o exactly 9 cycles later.
   - valid_i with operator MUL in IDLE -> ignored, busy_o stays 0.
6. rst_i asserted asynchronously mid-BUSY -> busy_o, result_valid_o and result_o=0 immediately; ready_o=1 after release.
